// File: rtl/round_ctrl.sv
// Round sequencer for the two-player factorization game: ready handshake,
// number request, timed answer window, judging, scoring and the STATE bus.
module round_ctrl #(
  parameter int ANSWER_TICKS = 500_000_000,
  parameter int SHOW_TICKS   = 100_000_000,
  parameter int WIN_SCORE    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_READY_1P,
  input  logic        BTN_READY_2P,
  input  logic        OK,
  input  logic [3:0]  NUM,
  input  logic        BTN_ANS_1P,
  input  logic        BTN_ANS_2P,
  input  logic [3:0]  ANS_1P,
  input  logic [3:0]  ANS_2P,
  output logic [3:0]  STATE,
  output logic        REQ,
  output logic [3:0]  CUR_NUM,
  output logic [3:0]  SCORE_1P,
  output logic [3:0]  SCORE_2P,
  output logic [31:0] TIMER
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'b0000,
    S_WAIT_READY = 4'b0001,
    S_DEAL       = 4'b0010,
    S_PLAY       = 4'b0011,
    S_JUDGE      = 4'b0100,
    S_DRAW       = 4'b0110,
    S_GOOD       = 4'b1000,
    S_OUCH       = 4'b1001,
    S_WIN        = 4'b1010,
    S_LOSE       = 4'b1011
  } state_t;

  localparam logic [31:0] ANSWER_LOAD = 32'(ANSWER_TICKS - 1);
  localparam logic [31:0] SHOW_LOAD   = 32'(SHOW_TICKS - 1);
  localparam logic [3:0]  WIN_VAL     = 4'(WIN_SCORE);

  state_t     state_reg;
  logic       rdy1_reg, rdy2_reg;
  logic       sub1_reg, sub2_reg;
  logic [3:0] ans1_reg, ans2_reg;

  logic       c1, c2, pt1, pt2;
  logic [3:0] score1_inc, score2_inc;

  // Bit a of the mask is set when answer a is accepted for number n;
  // bit 0 stands for the "no proper factor" answer.
  function automatic logic is_correct(input logic [3:0] n, input logic [3:0] a);
    logic [15:0] mask;
    case (n)
      4'd4:          mask = 16'h0004;
      4'd6:          mask = 16'h000C;
      4'd8:          mask = 16'h0014;
      4'd9:          mask = 16'h0008;
      4'd10:         mask = 16'h0024;
      4'd12:         mask = 16'h005C;
      4'd14:         mask = 16'h0084;
      4'd15:         mask = 16'h0028;
      4'd11, 4'd13:  mask = 16'h0000;
      default:       mask = 16'h0001;
    endcase
    return mask[a];
  endfunction

  always_comb begin
    c1 = is_correct(CUR_NUM, ans1_reg);
    c2 = is_correct(CUR_NUM, ans2_reg);
    pt1 = (sub1_reg & ~sub2_reg & c1) | (~sub1_reg & sub2_reg & ~c2) |
          (sub1_reg & sub2_reg & c1 & ~c2);
    pt2 = (sub2_reg & ~sub1_reg & c2) | (~sub2_reg & sub1_reg & ~c1) |
          (sub1_reg & sub2_reg & c2 & ~c1);
    score1_inc = SCORE_1P + 4'd1;
    score2_inc = SCORE_2P + 4'd1;
  end

  assign STATE = state_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      REQ       <= 1'b0;
      CUR_NUM   <= 4'd0;
      SCORE_1P  <= 4'd0;
      SCORE_2P  <= 4'd0;
      TIMER     <= 32'd0;
      rdy1_reg  <= 1'b0;
      rdy2_reg  <= 1'b0;
      sub1_reg  <= 1'b0;
      sub2_reg  <= 1'b0;
      ans1_reg  <= 4'd0;
      ans2_reg  <= 4'd0;
    end else begin
      REQ <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          SCORE_1P  <= 4'd0;
          SCORE_2P  <= 4'd0;
          CUR_NUM   <= 4'd0;
          TIMER     <= 32'd0;
          rdy1_reg  <= 1'b0;
          rdy2_reg  <= 1'b0;
          state_reg <= S_WAIT_READY;
        end
        S_WAIT_READY: begin
          if ((rdy1_reg | BTN_READY_1P) && (rdy2_reg | BTN_READY_2P)) begin
            REQ       <= 1'b1;
            rdy1_reg  <= 1'b0;
            rdy2_reg  <= 1'b0;
            state_reg <= S_DEAL;
          end else begin
            rdy1_reg <= rdy1_reg | BTN_READY_1P;
            rdy2_reg <= rdy2_reg | BTN_READY_2P;
          end
        end
        S_DEAL: begin
          if (OK) begin
            CUR_NUM   <= NUM;
            TIMER     <= ANSWER_LOAD;
            state_reg <= S_PLAY;
          end
        end
        S_PLAY: begin
          // A submit on the final tick wins over the timeout.
          if (BTN_ANS_1P || BTN_ANS_2P) begin
            sub1_reg  <= BTN_ANS_1P;
            sub2_reg  <= BTN_ANS_2P;
            ans1_reg  <= ANS_1P;
            ans2_reg  <= ANS_2P;
            TIMER     <= 32'd0;
            state_reg <= S_JUDGE;
          end else if (TIMER == 32'd0) begin
            TIMER     <= SHOW_LOAD;
            state_reg <= S_DRAW;
          end else begin
            TIMER <= TIMER - 32'd1;
          end
        end
        S_JUDGE: begin
          TIMER <= SHOW_LOAD;
          if (pt1) begin
            SCORE_1P  <= score1_inc;
            state_reg <= (score1_inc == WIN_VAL) ? S_WIN : S_GOOD;
          end else if (pt2) begin
            SCORE_2P  <= score2_inc;
            state_reg <= (score2_inc == WIN_VAL) ? S_LOSE : S_OUCH;
          end else begin
            state_reg <= S_DRAW;
          end
        end
        S_DRAW, S_GOOD, S_OUCH: begin
          if (TIMER == 32'd0) state_reg <= S_WAIT_READY;
          else                TIMER     <= TIMER - 32'd1;
        end
        S_WIN, S_LOSE: begin
          if (TIMER == 32'd0) state_reg <= S_IDLE;
          else                TIMER     <= TIMER - 32'd1;
        end
        default: begin
          TIMER     <= 32'd0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round sequencer for the two-player factorization game. It collects both players' ready presses and requests a number from the number generator. It then runs the answer window, arbitrates between the two players' answer submissions and judges them against the dealt number. Finally it keeps the match score and drives the shared 4-bit `STATE` bus that the number generator and display logic decode.

## Interface
- `ANSWER_TICKS`, default 500_000_000: cycles allowed in PLAY before timeout (10 s at 50 MHz).
- `SHOW_TICKS`, default 100_000_000: cycles a result state is held (2 s).
- `WIN_SCORE`, default 3: points that end the match; range 1..15.
- `CLK` in 1: system clock, all logic on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `BTN_READY_1P`, `BTN_READY_2P` in 1: ready presses, single-cycle pulses, debounced upstream.
- `OK` in 1: number generator valid strobe, qualifies `NUM`.
- `NUM` in 4: dealt number, 0..9.
- `BTN_ANS_1P`, `BTN_ANS_2P` in 1: answer submit pulses, single cycle.
- `ANS_1P`, `ANS_2P` in 4: answer values, sampled on the submit pulse.
- `STATE` out 4: current state code.
- `REQ` out 1: one-cycle request to the number generator.
- `CUR_NUM` out 4: number of the current round.
- `SCORE_1P`, `SCORE_2P` out 4: match scores.
- `TIMER` out 32: remaining cycles of the active PLAY or result window; 0 elsewhere.

## Operation
- State codes:
  - IDLE 0000, WAIT_READY 0001, DEAL 0010, PLAY 0011, JUDGE 0100.
  - DRAW 0110, GOOD 1000 (1P scores), OUCH 1001 (2P scores), WIN 1010 (1P takes match), LOSE 1011 (2P takes match).
  - Unused codes return to IDLE next cycle.
- IDLE: clears both scores and `CUR_NUM`, then goes to WAIT_READY after one cycle.
- WAIT_READY: latches `rdy1`/`rdy2` from the press pulses, with presses accepted in any order.
  - The cycle both latches are set, pulse `REQ` for one cycle, clear the latches, and go to DEAL.
  - Presses in any other state are ignored.
- DEAL: wait indefinitely for `OK`. On `OK`, capture `NUM` into `CUR_NUM`, load the timer with `ANSWER_TICKS-1`, and go to PLAY.
- PLAY:
  - The first cycle with any submit pulse captures the submitter(s) and their `ANS` values, then goes to JUDGE.
  - Later submits in the same round are ignored.
  - When the timer reaches 0 with no submit, go to DRAW.
- Correctness rule for answer A against number N:
  - If N ∈ {0,1,2,3,5,7}, the answer is correct iff A==0 (the "no proper factor" answer).
  - Otherwise, the answer is correct iff 2≤A<N and N mod A==0.
  - Accepted answers are therefore: 4→{2}, 6→{2,3}, 8→{2,4}, 9→{3}.
- JUDGE (one cycle), resolving the outcome:
  - Single submitter, correct: the submitter scores.
  - Single submitter, wrong: the opponent scores.
  - Both submit in the same cycle: exactly one correct means that player scores; both correct or both wrong goes to DRAW with no score change.
- Scoring:
  - A point to 1P increments `SCORE_1P` and goes to WIN if the new value equals `WIN_SCORE`, else GOOD.
  - A point to 2P is symmetric, going to LOSE or OUCH.
- Result states (DRAW/GOOD/OUCH/WIN/LOSE): load the timer with `SHOW_TICKS-1` on entry and count down.
  - At 0, GOOD/OUCH/DRAW go to WAIT_READY.
  - At 0, WIN/LOSE go to IDLE, starting a new match.
  - Scores hold through WIN/LOSE.

## Timing
- Reset values: `STATE`=0000 (IDLE), `REQ`=0, `CUR_NUM`=0, scores=0, `TIMER`=0, ready latches cleared.
- Reset asserted mid-round aborts immediately; no `REQ` is issued afterwards until both players press again.
- All outputs are registered.
- `STATE` changes on the clock edge after the triggering input is sampled.
- Latencies:
  - Second ready press at edge t gives `REQ`=1 and `STATE`=DEAL after edge t.
  - `OK` at edge t gives `STATE`=PLAY and `CUR_NUM` valid after edge t.
- Exactly `ANSWER_TICKS` cycles are spent in PLAY on timeout, and exactly `SHOW_TICKS` cycles in each result state.
- A submit arriving on the same cycle as timer==0 in PLAY is accepted; submit takes priority over timeout.
- `OK` outside DEAL is ignored.
- Score arithmetic is 4-bit and never exceeds `WIN_SCORE`, so it cannot wrap.

## Test plan
- Reset, then 1P ready at cycle 10 and 2P ready at cycle 20 -> exactly one `REQ` pulse in cycle 21, `STATE`=0010. A repeated 1P press in DEAL produces no second `REQ`.
- `OK` with `NUM`=6, then 1P submits `ANS`=3 -> JUDGE, GOOD, `SCORE_1P`=1, and GOOD held exactly `SHOW_TICKS` (5 in bench) cycles -> WAIT_READY.
- `NUM`=7, 2P submits 2 -> wrong -> GOOD for 1P. `NUM`=7, 2P submits 0 -> OUCH, `SCORE_2P` increments.
- `NUM`=8, both submit in the same cycle with 1P=4 and 2P=3 -> GOOD. Both submit 2 -> DRAW with scores unchanged.
- No submit with `ANSWER_TICKS`=20 -> DRAW after exactly 20 PLAY cycles. A submit on the last PLAY cycle is judged, not timed out.
- `WIN_SCORE`=2, 2P wins two rounds -> LOSE, then IDLE, then scores 0. Reset asserted during PLAY -> `STATE`=0000 asynchronously and all outputs at reset values.
